// File: rtl/reg_file_alu_pipe_pkg.sv
// Shared types for the register-file + ALU datapath: ALU opcode encoding and flag bundle.
package reg_file_alu_pkg;

    localparam int ALU_OP_W = 3;
    localparam int FLAGS_W  = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/reg_file_alu_pipe_alu_core.sv
// Combinational ALU: unsigned modulo arithmetic with carry/borrow, signed overflow and zero flags.
module alu_core
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output alu_flags_t        flags
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    // One extra bit holds carry-out for ADD and borrow for SUB.
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [SH_W-1:0]   shamt;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shamt    = b[SH_W-1:0];

    always_comb begin
        result         = '0;
        flags.overflow = 1'b0;
        flags.carry    = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result         = sum_ext[DATA_W-1:0];
                flags.carry    = sum_ext[DATA_W];
                flags.overflow = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result         = diff_ext[DATA_W-1:0];
                flags.carry    = diff_ext[DATA_W];
                flags.overflow = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SHL: result = a << shamt;
            ALU_SHR: result = a >> shamt;
            default: result = '0;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register-file + ALU core: ID captures operands (with EX->ID bypass),
// EX computes, then result/flags register and write-back happen on the same edge.
module reg_file_alu_pipe
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [AW-1:0]     RA1,
    input  logic [AW-1:0]     RA2,
    input  logic [AW-1:0]     WA,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUControl,
    input  logic [DATA_W-1:0] external_data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALUResult,
    output logic [2:0]        flags
);

    logic [DATA_W-1:0] regs_reg [NREGS];

    logic              ex_valid_reg;
    logic              ex_we_reg;
    logic [AW-1:0]     ex_wa_reg;
    alu_op_t           ex_op_reg;
    logic [DATA_W-1:0] ex_a_reg;
    logic [DATA_W-1:0] ex_b_reg;

    logic [DATA_W-1:0] alu_result;
    alu_flags_t        alu_flags;
    logic              wb_en;
    logic [NREGS-1:0]  wr_sel;
    logic [DATA_W-1:0] opa_next;
    logic [DATA_W-1:0] rb_next;
    logic [DATA_W-1:0] opb_next;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a      (ex_a_reg),
        .b      (ex_b_reg),
        .op     (ex_op_reg),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Register 0 is excluded here, so it is neither written nor a bypass source.
    assign wb_en = ex_valid_reg && ex_we_reg && (ex_wa_reg != '0);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_zero
                assign wr_sel[gi] = 1'b0;
            end else begin : g_reg
                assign wr_sel[gi] = wb_en && (ex_wa_reg == AW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                regs_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                regs_reg[i] <= alu_result;
            end
        end
    end

    // Operand read with bypass of the value being written back on this same edge.
    always_comb begin
        opa_next = '0;
        rb_next  = '0;
        if (RA1 != '0) begin
            opa_next = (wb_en && (ex_wa_reg == RA1)) ? alu_result : regs_reg[RA1];
        end
        if (RA2 != '0) begin
            rb_next = (wb_en && (ex_wa_reg == RA2)) ? alu_result : regs_reg[RA2];
        end
        opb_next = ALUSrc ? external_data_in : rb_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg <= 1'b0;
            ex_we_reg    <= 1'b0;
            ex_wa_reg    <= '0;
            ex_op_reg    <= ALU_AND;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
        end else begin
            ex_valid_reg <= in_valid;
            if (in_valid) begin
                ex_we_reg <= RegWrite;
                ex_wa_reg <= WA;
                ex_op_reg <= alu_op_t'(ALUControl);
                ex_a_reg  <= opa_next;
                ex_b_reg  <= opb_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
            flags     <= '0;
        end else begin
            out_valid <= ex_valid_reg;
            if (ex_valid_reg) begin
                ALUResult <= alu_result;
                flags     <= alu_flags;
            end
        end
    end

endmodule
